// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-SRAM arbiter.
package sram_arbiter_pkg;

  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 16;
  localparam int SRAM_ADDR_W   = 18;
  localparam int CNT_W         = 3;
  localparam int RD_CYCLES_DEF = 2;
  localparam int WR_CYCLES_DEF = 2;

  localparam logic RstEnable   = 1'b0;
  localparam logic StallYes    = 1'b1;
  localparam logic StallNo     = 1'b0;
  localparam logic SramEnable  = 1'b0;
  localparam logic SramDisable = 1'b1;

  localparam logic [DATA_W-1:0]      ZeroWord     = '0;
  localparam logic [SRAM_ADDR_W-1:0] ZeroSramAddr = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR_SU = 3'd2,
    WR_P  = 3'd3,
    WR_H  = 3'd4
  } state_e;

  function automatic logic [SRAM_ADDR_W-1:0] zext_addr(input logic [ADDR_W-1:0] a);
    return {{(SRAM_ADDR_W-ADDR_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester ports, SRAM pins and debug state of the arbiter, grouped as one bundle.
// Handshake: a requester holds req (and its address/data) until its ready pulses for one cycle.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic                   if_req_i;
  logic [ADDR_W-1:0]      if_addr_i;
  logic [DATA_W-1:0]      if_data_o;
  logic                   if_ready_o;
  logic                   mem_req_i;
  logic                   mem_we_i;
  logic [ADDR_W-1:0]      mem_addr_i;
  logic [DATA_W-1:0]      mem_wdata_i;
  logic [DATA_W-1:0]      mem_rdata_o;
  logic                   mem_ready_o;
  logic                   stall_req_o;
  logic [SRAM_ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0]      sram_dq_o;
  logic                   sram_dq_oe_o;
  logic [DATA_W-1:0]      sram_dq_i;
  logic                   sram_ce_n_o;
  logic                   sram_oe_n_o;
  logic                   sram_we_n_o;
  state_e                 state_o;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, sram_dq_i,
    output if_data_o, if_ready_o, mem_rdata_o, mem_ready_o, stall_req_o,
           sram_addr_o, sram_dq_o, sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, state_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, sram_dq_i,
    input  if_data_o, if_ready_o, mem_rdata_o, mem_ready_o, stall_req_o,
           sram_addr_o, sram_dq_o, sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, state_o
  );

endinterface

// File: rtl/sram_arbiter.sv
// Fixed-priority (MEM over IF) arbiter sequencing read/write timing on one async SRAM.
// Control outputs are registered as the values for the state being entered.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input logic            clk,
  input logic            rst,
  sram_arbiter_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   owner_mem_q, owner_mem_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      dq_q, dq_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic [DATA_W-1:0]      if_data_q, if_data_d;
  logic [DATA_W-1:0]      mem_rdata_q, mem_rdata_d;
  logic                   if_ready_q, if_ready_d;
  logic                   mem_ready_q, mem_ready_d;
  logic                   mem_ok, if_ok;

  // A requester whose ready is high this cycle is still holding a stale request.
  assign mem_ok = bus.mem_req_i & ~mem_ready_q;
  assign if_ok  = bus.if_req_i  & ~if_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    addr_d      = addr_q;
    dq_d        = dq_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ok) begin
          owner_mem_d = 1'b1;
          addr_d      = zext_addr(bus.mem_addr_i);
          ce_n_d      = SramEnable;
          if (bus.mem_we_i) begin
            dq_d    = bus.mem_wdata_i;
            dq_oe_d = 1'b1;
            state_d = WR_SU;
          end else begin
            oe_n_d  = SramEnable;
            cnt_d   = CNT_W'(RD_CYCLES - 1);
            state_d = RD;
          end
        end else if (if_ok) begin
          owner_mem_d = 1'b0;
          addr_d      = zext_addr(bus.if_addr_i);
          ce_n_d      = SramEnable;
          oe_n_d      = SramEnable;
          cnt_d       = CNT_W'(RD_CYCLES - 1);
          state_d     = RD;
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          if (owner_mem_q) begin
            mem_rdata_d = bus.sram_dq_i;
            mem_ready_d = 1'b1;
          end else begin
            if_data_d  = bus.sram_dq_i;
            if_ready_d = 1'b1;
          end
          ce_n_d  = SramDisable;
          oe_n_d  = SramDisable;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_SU: begin
        we_n_d  = SramEnable;
        cnt_d   = CNT_W'(WR_CYCLES - 1);
        state_d = WR_P;
      end
      WR_P: begin
        if (cnt_q == '0) begin
          we_n_d  = SramDisable;
          state_d = WR_H;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_H: begin
        ce_n_d      = SramDisable;
        dq_oe_d     = 1'b0;
        mem_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        ce_n_d  = SramDisable;
        oe_n_d  = SramDisable;
        we_n_d  = SramDisable;
        dq_oe_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_mem_q <= 1'b0;
      addr_q      <= ZeroSramAddr;
      dq_q        <= ZeroWord;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= SramDisable;
      oe_n_q      <= SramDisable;
      we_n_q      <= SramDisable;
      if_data_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      addr_q      <= addr_d;
      dq_q        <= dq_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign bus.stall_req_o  = (rst == RstEnable) ? StallNo :
                            ((if_ok | mem_ok) ? StallYes : StallNo);
  assign bus.if_data_o    = if_data_q;
  assign bus.if_ready_o   = if_ready_q;
  assign bus.mem_rdata_o  = mem_rdata_q;
  assign bus.mem_ready_o  = mem_ready_q;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_dq_o    = dq_q;
  assign bus.sram_dq_oe_o = dq_oe_q;
  assign bus.sram_ce_n_o  = ce_n_q;
  assign bus.sram_oe_n_o  = oe_n_q;
  assign bus.sram_we_n_o  = we_n_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle-exact checks against hand-computed timing,
// with a small SRAM model and an expected-data queue for returned reads.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   wr_count;
  int   wr_base;
  logic [SRAM_ADDR_W-1:0] last_wr_addr;
  logic [DATA_W-1:0]      last_wr_data;
  logic [DATA_W-1:0]      exp_q[$];

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: fixed read contents, writes captured at rising edges while WE is low
  function automatic logic [DATA_W-1:0] rom(input logic [SRAM_ADDR_W-1:0] a);
    case (a)
      18'h00010: return 16'h4A05;
      18'h00020: return 16'h1111;
      18'h00030: return 16'h2222;
      18'h00040: return 16'h3333;
      default:   return 16'hDEAD;
    endcase
  endfunction

  assign bus.sram_dq_i = (!bus.sram_ce_n_o && !bus.sram_oe_n_o) ? rom(bus.sram_addr_o) : 16'h0000;

  initial begin
    wr_count     = 0;
    last_wr_addr = '0;
    last_wr_data = '0;
  end

  always @(posedge clk) begin
    if (rst && !bus.sram_ce_n_o && !bus.sram_we_n_o && bus.sram_dq_oe_o) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= bus.sram_addr_o;
      last_wr_data <= bus.sram_dq_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // bus-contention invariants, checked every cycle
  always @(negedge clk) begin
    chk("oe_we_exclusive", {31'b0, !bus.sram_oe_n_o && !bus.sram_we_n_o}, 32'd0);
    chk("dq_oe_vs_oe",     {31'b0, bus.sram_dq_oe_o && !bus.sram_oe_n_o}, 32'd0);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_if_data"},   32'(bus.if_data_o),    32'h0);
    chk({pfx, "_mem_rdata"}, 32'(bus.mem_rdata_o),  32'h0);
    chk({pfx, "_if_ready"},  32'(bus.if_ready_o),   32'h0);
    chk({pfx, "_mem_ready"}, 32'(bus.mem_ready_o),  32'h0);
    chk({pfx, "_addr"},      32'(bus.sram_addr_o),  32'h0);
    chk({pfx, "_dq"},        32'(bus.sram_dq_o),    32'h0);
    chk({pfx, "_dq_oe"},     32'(bus.sram_dq_oe_o), 32'h0);
    chk({pfx, "_ce_n"},      32'(bus.sram_ce_n_o),  32'h1);
    chk({pfx, "_oe_n"},      32'(bus.sram_oe_n_o),  32'h1);
    chk({pfx, "_we_n"},      32'(bus.sram_we_n_o),  32'h1);
    chk({pfx, "_state"},     32'(bus.state_o),      32'(IDLE));
    chk({pfx, "_stall"},     32'(bus.stall_req_o),  32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("rst0");
    rst = 1'b1;
    tick();

    // IF-only read of 0x0010
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0010;
    exp_q.push_back(16'h4A05);
    #1;
    chk("if_c0_stall", 32'(bus.stall_req_o), 32'h1);
    chk("if_c0_oe_n",  32'(bus.sram_oe_n_o), 32'h1);
    tick();
    chk("if_c1_oe_n",  32'(bus.sram_oe_n_o),  32'h0);
    chk("if_c1_ce_n",  32'(bus.sram_ce_n_o),  32'h0);
    chk("if_c1_addr",  32'(bus.sram_addr_o),  32'h00010);
    chk("if_c1_dq_oe", 32'(bus.sram_dq_oe_o), 32'h0);
    chk("if_c1_ready", 32'(bus.if_ready_o),   32'h0);
    chk("if_c1_stall", 32'(bus.stall_req_o),  32'h1);
    tick();
    chk("if_c2_oe_n",  32'(bus.sram_oe_n_o),  32'h0);
    chk("if_c2_ready", 32'(bus.if_ready_o),   32'h0);
    chk("if_c2_stall", 32'(bus.stall_req_o),  32'h1);
    tick();
    chk("if_c3_ready", 32'(bus.if_ready_o),   32'h1);
    chk("if_c3_data",  32'(bus.if_data_o),    32'(exp_q.pop_front()));
    chk("if_c3_oe_n",  32'(bus.sram_oe_n_o),  32'h1);
    chk("if_c3_stall", 32'(bus.stall_req_o),  32'h0);
    chk("if_c3_mrdy",  32'(bus.mem_ready_o),  32'h0);
    bus.if_req_i = 1'b0;
    tick();
    chk("if_c4_ready", 32'(bus.if_ready_o), 32'h0);
    chk("if_c4_hold",  32'(bus.if_data_o),  32'h4A05);
    chk("if_c4_state", 32'(bus.state_o),    32'(IDLE));
    chk("if_c4_ce_n",  32'(bus.sram_ce_n_o), 32'h1);

    // store 0x1234 to 0x8000
    wr_base         = wr_count;
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_addr_i  = 16'h8000;
    bus.mem_wdata_i = 16'h1234;
    #1;
    chk("st_c0_stall", 32'(bus.stall_req_o), 32'h1);
    tick();
    chk("st_c1_state", 32'(bus.state_o),      32'(WR_SU));
    chk("st_c1_dq_oe", 32'(bus.sram_dq_oe_o), 32'h1);
    chk("st_c1_we_n",  32'(bus.sram_we_n_o),  32'h1);
    chk("st_c1_ce_n",  32'(bus.sram_ce_n_o),  32'h0);
    chk("st_c1_oe_n",  32'(bus.sram_oe_n_o),  32'h1);
    chk("st_c1_addr",  32'(bus.sram_addr_o),  32'h08000);
    chk("st_c1_dq",    32'(bus.sram_dq_o),    32'h1234);
    tick();
    chk("st_c2_we_n",  32'(bus.sram_we_n_o),  32'h0);
    chk("st_c2_state", 32'(bus.state_o),      32'(WR_P));
    tick();
    chk("st_c3_we_n",  32'(bus.sram_we_n_o),  32'h0);
    chk("st_c3_dq_oe", 32'(bus.sram_dq_oe_o), 32'h1);
    tick();
    chk("st_c4_state", 32'(bus.state_o),      32'(WR_H));
    chk("st_c4_we_n",  32'(bus.sram_we_n_o),  32'h1);
    chk("st_c4_dq_oe", 32'(bus.sram_dq_oe_o), 32'h1);
    chk("st_c4_ready", 32'(bus.mem_ready_o),  32'h0);
    tick();
    chk("st_c5_ready", 32'(bus.mem_ready_o),  32'h1);
    chk("st_c5_dq_oe", 32'(bus.sram_dq_oe_o), 32'h0);
    chk("st_c5_ce_n",  32'(bus.sram_ce_n_o),  32'h1);
    chk("st_wr_count", 32'(wr_count - wr_base), 32'd2);
    chk("st_wr_addr",  32'(last_wr_addr),     32'h08000);
    chk("st_wr_data",  32'(last_wr_data),     32'h1234);
    idle_inputs();
    tick();
    chk("st_c6_ready", 32'(bus.mem_ready_o), 32'h0);

    // simultaneous: IF 0x0020 and MEM load 0x0030 in the same cycle
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 16'h0020;
    bus.mem_req_i  = 1'b1;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = 16'h0030;
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h1111);
    tick();
    chk("sim_c1_addr",  32'(bus.sram_addr_o), 32'h00030);
    chk("sim_c1_oe_n",  32'(bus.sram_oe_n_o), 32'h0);
    tick();
    tick();
    chk("sim_c3_mrdy",  32'(bus.mem_ready_o), 32'h1);
    chk("sim_c3_mdata", 32'(bus.mem_rdata_o), 32'(exp_q.pop_front()));
    chk("sim_c3_irdy",  32'(bus.if_ready_o),  32'h0);
    chk("sim_c3_state", 32'(bus.state_o),     32'(IDLE));
    chk("sim_c3_oe_n",  32'(bus.sram_oe_n_o), 32'h1);
    chk("sim_c3_stall", 32'(bus.stall_req_o), 32'h1);
    bus.mem_req_i = 1'b0;
    tick();
    chk("sim_c4_state", 32'(bus.state_o),     32'(RD));
    chk("sim_c4_addr",  32'(bus.sram_addr_o), 32'h00020);
    chk("sim_c4_mrdy",  32'(bus.mem_ready_o), 32'h0);
    tick();
    chk("sim_c5_irdy",  32'(bus.if_ready_o),  32'h0);
    tick();
    chk("sim_c6_irdy",  32'(bus.if_ready_o),  32'h1);
    chk("sim_c6_idata", 32'(bus.if_data_o),   32'(exp_q.pop_front()));
    chk("sim_c6_mhold", 32'(bus.mem_rdata_o), 32'h2222);
    bus.if_req_i = 1'b0;
    tick();
    chk("sim_c7_irdy",  32'(bus.if_ready_o),  32'h0);

    // IF drops its request in cycle 1 of a read
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0040;
    exp_q.push_back(16'h3333);
    tick();
    bus.if_req_i = 1'b0;
    #1;
    chk("drop_c1_stall", 32'(bus.stall_req_o), 32'h0);
    chk("drop_c1_state", 32'(bus.state_o),     32'(RD));
    tick();
    tick();
    chk("drop_c3_irdy",  32'(bus.if_ready_o),  32'h1);
    chk("drop_c3_idata", 32'(bus.if_data_o),   32'(exp_q.pop_front()));
    chk("drop_c3_mrdy",  32'(bus.mem_ready_o), 32'h0);
    tick();
    chk("drop_c4_state", 32'(bus.state_o),     32'(IDLE));
    chk("drop_c4_oe_n",  32'(bus.sram_oe_n_o), 32'h1);
    chk("drop_c4_irdy",  32'(bus.if_ready_o),  32'h0);
    tick();
    chk("drop_c5_state", 32'(bus.state_o),     32'(IDLE));

    // reset asserted during WR_P, before any write edge is seen by the SRAM
    wr_base         = wr_count;
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_addr_i  = 16'h0050;
    bus.mem_wdata_i = 16'hBEEF;
    tick();
    chk("rwp_c1_state", 32'(bus.state_o), 32'(WR_SU));
    tick();
    chk("rwp_c2_state", 32'(bus.state_o),     32'(WR_P));
    chk("rwp_c2_we_n",  32'(bus.sram_we_n_o), 32'h0);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_values("rwp");
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();
    chk("rwp_post_state", 32'(bus.state_o),      32'(IDLE));
    chk("rwp_post_ce_n",  32'(bus.sram_ce_n_o),  32'h1);
    chk("rwp_post_mrdy",  32'(bus.mem_ready_o),  32'h0);
    chk("rwp_no_write",   32'(wr_count - wr_base), 32'd0);
    chk("exp_q_empty",    32'(exp_q.size()),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
